// File: rtl/actor_mul_mdc.sv
// actor_mul_mdc: dataflow multiply actor between two operand FIFOs and one
// result FIFO. Each transaction reads one token from each input FIFO,
// multiplies them (unsigned or two's-complement) and writes the low out_size
// bits of the product to the result FIFO.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   valid_a    operand-A FIFO not empty
//   dataout_a  operand-A FIFO head token
//   enr_a      operand-A FIFO read strobe
//   valid_b    operand-B FIFO not empty
//   dataout_b  operand-B FIFO head token
//   enr_b      operand-B FIFO read strobe
//   full       result FIFO cannot accept a token
//   datain     result token
//   enw        result FIFO write strobe
//   busy       FSM is not idle
//   count      number of result tokens written since reset (wraps)
module actor_mul_mdc #(
  parameter int size        = 8,
  parameter int out_size    = 16,
  parameter int signed_mode = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_a,
  input  logic [size-1:0]     dataout_a,
  output logic                enr_a,
  input  logic                valid_b,
  input  logic [size-1:0]     dataout_b,
  output logic                enr_b,
  input  logic                full,
  output logic [out_size-1:0] datain,
  output logic                enw,
  output logic                busy,
  output logic [15:0]         count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    MUL   = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [size-1:0]   op_a, op_b;
  logic [2*size-1:0] prod;
  logic [2*size-1:0] ext_a, ext_b;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (valid_a && valid_b) state_nxt = READ;
      READ:    state_nxt = MUL;
      MUL:     state_nxt = WRITE;
      WRITE:   if (!full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    enr_a = 1'b0;
    enr_b = 1'b0;
    enw   = 1'b0;
    busy  = (state != IDLE);
    unique case (state)
      READ: begin
        enr_a = 1'b1;
        enr_b = 1'b1;
      end
      WRITE:   enw = !full;
      default: ;
    endcase
  end

  // Extending both operands to the full product width before multiplying
  // gives the correct 2*size-bit product for either signedness.
  always_comb begin
    if (signed_mode != 0) begin
      ext_a = {{size{op_a[size-1]}}, op_a};
      ext_b = {{size{op_b[size-1]}}, op_b};
    end else begin
      ext_a = {{size{1'b0}}, op_a};
      ext_b = {{size{1'b0}}, op_b};
    end
  end

  // Datapath: operand capture leaving READ, product capture leaving MUL
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a <= '0;
      op_b <= '0;
      prod <= '0;
    end else begin
      if (state == READ) begin
        op_a <= dataout_a;
        op_b <= dataout_b;
      end
      if (state == MUL) prod <= ext_a * ext_b;
    end
  end

  // Written-token counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     count <= '0;
    else if (enw) count <= count + 16'd1;
  end

  assign datain = prod[out_size-1:0];

endmodule

// File: tb/tb_actor_mul_mdc.sv
module tb_actor_mul_mdc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_a = 1'b0, valid_b = 1'b0, full = 1'b0;
  logic [7:0]  dataout_a = '0, dataout_b = '0;
  logic        enr_a, enr_b, enw, busy;
  logic [15:0] datain, count;

  logic        s_valid = 1'b0, s_full = 1'b0;
  logic [7:0]  s_a = '0, s_b = '0;
  logic        s_enr_a, s_enr_b, s_enw, s_busy;
  logic [15:0] s_datain, s_count;

  always #5 clk = ~clk;

  actor_mul_mdc #(.size(8), .out_size(16), .signed_mode(0)) dut (
    .clk(clk), .rst(rst),
    .valid_a(valid_a), .dataout_a(dataout_a), .enr_a(enr_a),
    .valid_b(valid_b), .dataout_b(dataout_b), .enr_b(enr_b),
    .full(full), .datain(datain), .enw(enw), .busy(busy), .count(count)
  );

  actor_mul_mdc #(.size(8), .out_size(16), .signed_mode(1)) dut_s (
    .clk(clk), .rst(rst),
    .valid_a(s_valid), .dataout_a(s_a), .enr_a(s_enr_a),
    .valid_b(s_valid), .dataout_b(s_b), .enr_b(s_enr_b),
    .full(s_full), .datain(s_datain), .enw(s_enw), .busy(s_busy), .count(s_count)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  logic [7:0]  qa[$], qb[$];
  logic [15:0] res_q[$], s_res[$];
  int          res_t[$];
  int          cyc = 0, rd_cnt = 0, pair_err = 0;
  int          tests = 0, fails = 0;
  int          ecount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic upd_fifo();
    valid_a   = (qa.size() != 0);
    valid_b   = (qb.size() != 0);
    dataout_a = valid_a ? qa[0] : 8'h00;
    dataout_b = valid_b ? qb[0] : 8'h00;
  endtask

  // One clock: record strobes seen before the edge, then update FIFO models.
  task automatic tick();
    logic ra, rb, sra;
    ra  = enr_a;
    rb  = enr_b;
    sra = s_enr_a;
    if (enr_a !== enr_b) pair_err++;
    if (enw) begin
      res_q.push_back(datain);
      res_t.push_back(cyc + 1);
    end
    if (s_enw) s_res.push_back(s_datain);
    @(posedge clk);
    cyc++;
    #1;
    if (ra) begin
      rd_cnt++;
      if (qa.size() != 0) void'(qa.pop_front());
    end
    if (rb && qb.size() != 0) void'(qb.pop_front());
    if (sra) s_valid = 1'b0;
    upd_fifo();
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    qa.push_back(a);
    qb.push_back(b);
    upd_fifo();
    #1;
  endtask

  task automatic wait_results(input int n, input int bound);
    int k;
    k = 0;
    while (res_q.size() < n && k < bound) begin
      tick();
      k++;
    end
    if (res_q.size() < n) check("timeout_results", res_q.size(), n);
  endtask

  task automatic clear_res();
    res_q.delete();
    res_t.delete();
  endtask

  task automatic signed_case(input logic [7:0] a, input logic [7:0] b,
                             input logic [15:0] exp, input string name);
    int k;
    s_res.delete();
    s_a = a;
    s_b = b;
    s_valid = 1'b1;
    k = 0;
    while (s_res.size() < 1 && k < 20) begin
      tick();
      k++;
    end
    if (s_res.size() < 1) check("timeout_signed", 0, 1);
    else check(name, s_res[0], exp);
  endtask

  initial begin
    int start, rd0;
    logic [7:0] ba[8], bb[8];

    vecs[0] = '{a: 8'd3,  b: 8'd5,  exp: 16'd15};
    vecs[1] = '{a: 8'hFF, b: 8'hFF, exp: 16'hFE01};
    vecs[2] = '{a: 8'h00, b: 8'h77, exp: 16'h0000};
    vecs[3] = '{a: 8'h80, b: 8'h02, exp: 16'h0100};
    vecs[4] = '{a: 8'h12, b: 8'h34, exp: 16'h03A8};
    vecs[5] = '{a: 8'hFF, b: 8'h01, exp: 16'h00FF};

    // Reset state
    tick();
    tick();
    check("rst_enr_a", enr_a, 0);
    check("rst_enr_b", enr_b, 0);
    check("rst_enw", enw, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_datain", datain, 0);
    rst = 1'b1;
    tick();

    // Table-driven single tokens
    for (int i = 0; i < 6; i++) begin
      clear_res();
      start = cyc;
      push(vecs[i].a, vecs[i].b);
      tick();
      check($sformatf("v%0d_enr_a", i), enr_a, 1);
      check($sformatf("v%0d_busy", i), busy, 1);
      tick();
      check($sformatf("v%0d_enr_off", i), enr_a, 0);
      wait_results(1, 20);
      ecount++;
      if (res_q.size() > 0) begin
        check($sformatf("v%0d_datain", i), res_q[0], vecs[i].exp);
        check($sformatf("v%0d_latency", i), res_t[0] - start, 4);
      end
      check($sformatf("v%0d_count", i), count, ecount);
      check($sformatf("v%0d_idle", i), busy, 0);
    end

    // Signed instance
    signed_case(8'hFF, 8'hFF, 16'h0001, "signed_ff_ff");
    signed_case(8'hFD, 8'h05, 16'hFFF1, "signed_m3_5");
    signed_case(8'h80, 8'h01, 16'hFF80, "signed_m128_1");

    // Only valid_a: nothing may happen
    clear_res();
    rd0 = rd_cnt;
    qa.push_back(8'h11);
    upd_fifo();
    #1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("onlya_busy", busy, 0);
      check("onlya_enr", enr_a | enr_b | enw, 0);
    end
    check("onlya_reads", rd_cnt - rd0, 0);
    qa.delete();
    upd_fifo();
    #1;

    // Backpressure: full held for 5 cycles of WRITE
    clear_res();
    full = 1'b1;
    push(8'd7, 8'd9);
    push(8'd2, 8'd3);
    tick();
    tick();
    tick();
    rd0 = rd_cnt;
    for (int k = 0; k < 5; k++) begin
      check("full_enw", enw, 0);
      check("full_datain", datain, 16'h003F);
      check("full_enr", enr_a, 0);
      check("full_busy", busy, 1);
      tick();
    end
    check("full_reads", rd_cnt - rd0, 0);
    full = 1'b0;
    #1;
    check("full_release_enw", enw, 1);
    tick();
    check("full_one_result", res_q.size(), 1);
    check("full_idle", busy, 0);
    wait_results(2, 20);
    ecount += 2;
    if (res_q.size() >= 2) begin
      check("full_res0", res_q[0], 16'h003F);
      check("full_res1", res_q[1], 16'h0006);
    end
    check("full_count", count, ecount);

    // Reset during MUL
    clear_res();
    push(8'd10, 8'd10);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_enw", enw, 0);
    check("mrst_enr", enr_a, 0);
    check("mrst_count", count, 0);
    check("mrst_datain", datain, 0);
    tick();
    rst = 1'b1;
    ecount = 0;
    tick();
    tick();
    check("mrst_no_result", res_q.size(), 0);
    push(8'd6, 8'd7);
    wait_results(1, 20);
    ecount++;
    if (res_q.size() > 0) check("mrst_next", res_q[0], 16'd42);
    check("mrst_count_after", count, ecount);

    // Eight back-to-back tokens
    clear_res();
    rd0 = rd_cnt;
    for (int i = 0; i < 8; i++) begin
      ba[i] = 8'(i * 37 + 5);
      bb[i] = 8'(250 - i * 11);
      qa.push_back(ba[i]);
      qb.push_back(bb[i]);
    end
    upd_fifo();
    #1;
    wait_results(8, 100);
    for (int i = 0; i < 8 && i < res_q.size(); i++) begin
      check($sformatf("b2b_res%0d", i), res_q[i], 16'(ba[i]) * 16'(bb[i]));
      if (i > 0) check($sformatf("b2b_period%0d", i), res_t[i] - res_t[i-1], 4);
    end
    for (int k = 0; k < 10; k++) tick();
    ecount += 8;
    check("b2b_reads", rd_cnt - rd0, 8);
    check("b2b_count", count, ecount);
    check("b2b_no_extra", res_q.size(), 8);
    check("enr_pairing", pair_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
